// File: rtl/cmd_sequencer.sv
// Receive-side command sequencer: decodes the RX byte protocol into register-file
// writes/reads and ALU operations, and streams results byte-wise into the TX FIFO.
module cmd_sequencer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] RF_WR_CMD   = DATA_WIDTH'(8'hAA),
  parameter logic [DATA_WIDTH-1:0] RF_RD_CMD   = DATA_WIDTH'(8'hBB),
  parameter logic [DATA_WIDTH-1:0] ALU_OP_CMD  = DATA_WIDTH'(8'hCC),
  parameter logic [DATA_WIDTH-1:0] ALU_NOP_CMD = DATA_WIDTH'(8'hDD)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_VLD,
  output logic [ADDR_WIDTH-1:0]   RF_ADDR,
  output logic                    RF_WR_EN,
  output logic                    RF_RD_EN,
  output logic [DATA_WIDTH-1:0]   RF_WR_DATA,
  input  logic [DATA_WIDTH-1:0]   RF_RD_DATA,
  input  logic                    RF_RD_VLD,
  output logic [3:0]              ALU_FUN,
  output logic                    ALU_EN,
  output logic                    CLK_GATE_EN,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VLD,
  output logic [DATA_WIDTH-1:0]   FIFO_WR_DATA,
  output logic                    FIFO_WR_INC,
  input  logic                    FIFO_FULL
);

  localparam int unsigned FUN_WIDTH = 4;

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B,
    ALU_FUN_S, ALU_WAIT, TX_LO, TX_HI
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [2*DATA_WIDTH-1:0] alu_res;
  logic [DATA_WIDTH-1:0]   rd_byte;
  logic                    rd_pend;

  // Strobes default low every cycle so each assertion is a single-cycle pulse.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= IDLE;
      wr_addr      <= '0;
      alu_res      <= '0;
      rd_byte      <= '0;
      rd_pend      <= 1'b0;
      RF_ADDR      <= '0;
      RF_WR_EN     <= 1'b0;
      RF_RD_EN     <= 1'b0;
      RF_WR_DATA   <= '0;
      ALU_FUN      <= '0;
      ALU_EN       <= 1'b0;
      CLK_GATE_EN  <= 1'b0;
      FIFO_WR_DATA <= '0;
      FIFO_WR_INC  <= 1'b0;
    end else begin
      RF_WR_EN    <= 1'b0;
      RF_RD_EN    <= 1'b0;
      FIFO_WR_INC <= 1'b0;
      case (state)
        IDLE: begin
          if (RX_D_VLD) begin
            if (RX_P_DATA == RF_WR_CMD)        state <= WR_ADDR;
            else if (RX_P_DATA == RF_RD_CMD)   state <= RD_ADDR;
            else if (RX_P_DATA == ALU_OP_CMD)  state <= OP_A;
            else if (RX_P_DATA == ALU_NOP_CMD) state <= ALU_FUN_S;
          end
        end
        WR_ADDR: begin
          if (RX_D_VLD) begin
            wr_addr <= RX_P_DATA[ADDR_WIDTH-1:0];
            state   <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (RX_D_VLD) begin
            RF_WR_EN   <= 1'b1;
            RF_ADDR    <= wr_addr;
            RF_WR_DATA <= RX_P_DATA;
            state      <= IDLE;
          end
        end
        RD_ADDR: begin
          if (RX_D_VLD) begin
            RF_RD_EN <= 1'b1;
            RF_ADDR  <= RX_P_DATA[ADDR_WIDTH-1:0];
            state    <= RD_WAIT;
          end
        end
        // Read data is parked in rd_byte until the FIFO can take it.
        RD_WAIT: begin
          if (rd_pend) begin
            if (!FIFO_FULL) begin
              FIFO_WR_INC  <= 1'b1;
              FIFO_WR_DATA <= rd_byte;
              rd_pend      <= 1'b0;
              state        <= IDLE;
            end
          end else if (RF_RD_VLD) begin
            rd_byte <= RF_RD_DATA;
            rd_pend <= 1'b1;
          end
        end
        OP_A: begin
          if (RX_D_VLD) begin
            RF_WR_EN   <= 1'b1;
            RF_ADDR    <= ADDR_WIDTH'(0);
            RF_WR_DATA <= RX_P_DATA;
            state      <= OP_B;
          end
        end
        OP_B: begin
          if (RX_D_VLD) begin
            RF_WR_EN   <= 1'b1;
            RF_ADDR    <= ADDR_WIDTH'(1);
            RF_WR_DATA <= RX_P_DATA;
            state      <= ALU_FUN_S;
          end
        end
        ALU_FUN_S: begin
          if (RX_D_VLD) begin
            ALU_FUN     <= RX_P_DATA[FUN_WIDTH-1:0];
            CLK_GATE_EN <= 1'b1;
            state       <= ALU_WAIT;
          end
        end
        // ALU_EN rises one cycle behind the clock gate so the gated clock is running first.
        ALU_WAIT: begin
          if (ALU_OUT_VLD) begin
            alu_res     <= ALU_OUT;
            ALU_EN      <= 1'b0;
            CLK_GATE_EN <= 1'b0;
            state       <= TX_LO;
          end else begin
            ALU_EN <= 1'b1;
          end
        end
        TX_LO: begin
          if (!FIFO_FULL) begin
            FIFO_WR_INC  <= 1'b1;
            FIFO_WR_DATA <= alu_res[DATA_WIDTH-1:0];
            state        <= TX_HI;
          end
        end
        TX_HI: begin
          if (!FIFO_FULL) begin
            FIFO_WR_INC  <= 1'b1;
            FIFO_WR_DATA <= alu_res[2*DATA_WIDTH-1:DATA_WIDTH];
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_sequencer.sv
// Bench for cmd_sequencer: directed scenarios plus a randomized command stream
// checked against a transaction-level model of the byte protocol.
module tb_cmd_sequencer;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic [DW-1:0] RX_P_DATA;
  logic          RX_D_VLD;
  logic [AW-1:0] RF_ADDR;
  logic          RF_WR_EN, RF_RD_EN;
  logic [DW-1:0] RF_WR_DATA, RF_RD_DATA;
  logic          RF_RD_VLD;
  logic [3:0]    ALU_FUN;
  logic          ALU_EN, CLK_GATE_EN;
  logic [2*DW-1:0] ALU_OUT;
  logic          ALU_OUT_VLD;
  logic [DW-1:0] FIFO_WR_DATA;
  logic          FIFO_WR_INC, FIFO_FULL;

  cmd_sequencer dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RF_ADDR(RF_ADDR), .RF_WR_EN(RF_WR_EN), .RF_RD_EN(RF_RD_EN),
    .RF_WR_DATA(RF_WR_DATA), .RF_RD_DATA(RF_RD_DATA), .RF_RD_VLD(RF_RD_VLD),
    .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN), .CLK_GATE_EN(CLK_GATE_EN),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
    .FIFO_WR_DATA(FIFO_WR_DATA), .FIFO_WR_INC(FIFO_WR_INC), .FIFO_FULL(FIFO_FULL)
  );

  always #5 CLK = ~CLK;

  typedef struct packed { logic [3:0] a; logic [7:0] d; } wr_t;

  logic [7:0]  rf_mem  [16];
  logic [7:0]  ref_mem [16];
  logic [3:0]  rd_addr_q;
  int          rd_dly, alu_cnt, alu_delay, alu_vld_cnt, gate_err, excl_err, cyc;
  logic [15:0] alu_value;
  bit          rand_full;
  wr_t         act_wr[$], exp_wr[$];
  logic [7:0]  act_fifo[$], exp_fifo[$];
  int          fifo_cyc[$];
  logic [3:0]  act_rd[$], exp_rd[$], act_fun[$], exp_fun[$];
  int          checks, errors;

  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor plus register-file and ALU responders, all acting mid-cycle.
  always @(negedge CLK) begin
    if (RF_WR_EN) begin
      act_wr.push_back({RF_ADDR, RF_WR_DATA});
      rf_mem[RF_ADDR] = RF_WR_DATA;
    end
    if (RF_RD_EN) act_rd.push_back(RF_ADDR);
    if (FIFO_WR_INC) begin
      act_fifo.push_back(FIFO_WR_DATA);
      fifo_cyc.push_back(cyc);
    end
    if (int'(RF_WR_EN) + int'(RF_RD_EN) + int'(FIFO_WR_INC) > 1) excl_err++;
    if (RF_WR_EN && ALU_EN) excl_err++;
    if (ALU_EN && !CLK_GATE_EN) gate_err++;
    RF_RD_VLD = 1'b0;
    if (rd_dly > 0) begin
      rd_dly--;
      if (rd_dly == 0) begin
        RF_RD_VLD  = 1'b1;
        RF_RD_DATA = rf_mem[rd_addr_q];
      end
    end
    if (RF_RD_EN) begin
      rd_dly    = 2;
      rd_addr_q = RF_ADDR;
    end
    ALU_OUT_VLD = 1'b0;
    if (ALU_EN) begin
      if (alu_cnt >= alu_delay) begin
        ALU_OUT_VLD = 1'b1;
        ALU_OUT     = alu_value;
        alu_cnt     = 0;
        alu_vld_cnt++;
        act_fun.push_back(ALU_FUN);
        if (!CLK_GATE_EN) gate_err++;
      end else begin
        alu_cnt++;
      end
    end else begin
      alu_cnt = 0;
    end
  end

  function automatic logic [28:0] all_outs();
    return {RF_ADDR, RF_WR_EN, RF_RD_EN, RF_WR_DATA, ALU_FUN, ALU_EN, CLK_GATE_EN,
            FIFO_WR_DATA, FIFO_WR_INC};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge CLK);
      if (rand_full) FIFO_FULL = ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    tick(1);
    RX_D_VLD  = 1'b0;
    RX_P_DATA = 8'($urandom);
    tick(int'($urandom_range(0, 2)));
  endtask

  task automatic wait_fifo(input int n);
    int k = 0;
    while (act_fifo.size() < n && k < 400) begin
      tick(1);
      k++;
    end
    tick(3);
  endtask

  task automatic clear_logs();
    act_wr.delete(); act_fifo.delete(); fifo_cyc.delete(); act_rd.delete(); act_fun.delete();
    alu_vld_cnt = 0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick(2);
    checks++;
    if (all_outs() !== 29'h0) begin
      errors++; $display("FAIL reset_outputs got %h exp 0", all_outs());
    end
    RST = 1'b0;
    tick(3);
    checks++;
    if (all_outs() !== 29'h0) begin
      errors++; $display("FAIL idle_after_reset got %h exp 0", all_outs());
    end
  endtask

  task automatic test_write();
    clear_logs();
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'hD2);
    ref_mem[5] = 8'hD2;
    tick(4);
    checks++;
    if (act_wr.size() != 1) begin
      errors++; $display("FAIL write_count got %0d exp 1", act_wr.size());
    end else begin
      checks++;
      if (act_wr[0] !== wr_t'({4'h5, 8'hD2})) begin
        errors++; $display("FAIL write_addr_data got %h exp 5d2", act_wr[0]);
      end
    end
    checks++;
    if (act_fifo.size() + act_rd.size() != 0) begin
      errors++; $display("FAIL write_side_effects got %0d exp 0", act_fifo.size() + act_rd.size());
    end
  endtask

  task automatic test_read();
    clear_logs();
    send_byte(8'hBB); send_byte(8'h05);
    wait_fifo(1);
    checks++;
    if (act_rd.size() != 1 || act_rd[0] !== 4'h5) begin
      errors++; $display("FAIL read_strobe count %0d exp 1 at addr 5", act_rd.size());
    end
    checks++;
    if (act_fifo.size() != 1) begin
      errors++; $display("FAIL read_push_count got %0d exp 1", act_fifo.size());
    end else begin
      checks++;
      if (act_fifo[0] !== ref_mem[5]) begin
        errors++; $display("FAIL read_data got %h exp %h", act_fifo[0], ref_mem[5]);
      end
    end
    checks++;
    if (act_wr.size() != 0) begin
      errors++; $display("FAIL read_no_write got %0d exp 0", act_wr.size());
    end
  endtask

  task automatic test_alu_op();
    logic [15:0] sum;
    clear_logs();
    gate_err  = 0;
    alu_delay = 6;
    sum       = 16'(8'hAD) + 16'(8'h81);
    alu_value = sum;
    send_byte(8'hCC); send_byte(8'hAD); send_byte(8'h81); send_byte(8'h00);
    send_byte(8'hBB);
    wait_fifo(2);
    ref_mem[0] = 8'hAD; ref_mem[1] = 8'h81;
    checks++;
    if (act_wr.size() != 2) begin
      errors++; $display("FAIL op_write_count got %0d exp 2", act_wr.size());
    end else begin
      checks++;
      if (act_wr[0] !== wr_t'({4'h0, 8'hAD}) || act_wr[1] !== wr_t'({4'h1, 8'h81})) begin
        errors++; $display("FAIL op_operands got %h %h exp 0ad 181", act_wr[0], act_wr[1]);
      end
    end
    checks++;
    if (act_fun.size() != 1 || act_fun[0] !== 4'h0 || gate_err != 0) begin
      errors++; $display("FAIL op_alu_fun vld %0d gate_err %0d exp one vld fun 0", act_fun.size(), gate_err);
    end
    checks++;
    if (act_fifo.size() != 2) begin
      errors++; $display("FAIL op_push_count got %0d exp 2", act_fifo.size());
    end else begin
      checks++;
      if ({act_fifo[1], act_fifo[0]} !== sum) begin
        errors++; $display("FAIL op_result got %h%h exp %h", act_fifo[1], act_fifo[0], sum);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_logs();
    alu_delay = 2;
    alu_value = 16'h0047;
    send_byte(8'hDD); send_byte(8'h0C);
    wait_fifo(2);
    checks++;
    if (act_wr.size() != 0 || act_fun.size() != 1 || act_fun[0] !== 4'hC) begin
      errors++; $display("FAIL nop_fun writes %0d vld %0d exp 0 writes fun c", act_wr.size(), act_fun.size());
    end
    checks++;
    if (act_fifo.size() != 2) begin
      errors++; $display("FAIL nop_push_count got %0d exp 2", act_fifo.size());
    end else begin
      checks++;
      if (act_fifo[0] !== 8'h47 || act_fifo[1] !== 8'h00) begin
        errors++; $display("FAIL nop_result got %h %h exp 47 00", act_fifo[0], act_fifo[1]);
      end
      checks++;
      if (fifo_cyc[1] - fifo_cyc[0] != 1) begin
        errors++; $display("FAIL push_spacing got %0d exp 1", fifo_cyc[1] - fifo_cyc[0]);
      end
    end
  endtask

  task automatic test_backpressure();
    int k = 0;
    clear_logs();
    FIFO_FULL = 1'b1;
    alu_delay = 2;
    alu_value = 16'hBEEF;
    send_byte(8'hDD); send_byte(8'h03);
    while (alu_vld_cnt == 0 && k < 100) begin tick(1); k++; end
    tick(20);
    checks++;
    if (alu_vld_cnt != 1 || act_fifo.size() != 0) begin
      errors++; $display("FAIL full_hold vld %0d pushes %0d exp 1 0", alu_vld_cnt, act_fifo.size());
    end
    FIFO_FULL = 1'b0;
    wait_fifo(2);
    checks++;
    if (act_fifo.size() != 2) begin
      errors++; $display("FAIL full_release_count got %0d exp 2", act_fifo.size());
    end else begin
      checks++;
      if (act_fifo[0] !== 8'hEF || act_fifo[1] !== 8'hBE) begin
        errors++; $display("FAIL full_release_order got %h %h exp ef be", act_fifo[0], act_fifo[1]);
      end
    end
  endtask

  task automatic test_ignore();
    clear_logs();
    send_byte(8'h55);
    send_byte(8'hAA); send_byte(8'hF7); send_byte(8'h44);
    ref_mem[7] = 8'h44;
    tick(4);
    checks++;
    if (act_wr.size() != 1 || act_wr[0] !== wr_t'({4'h7, 8'h44}) || act_fifo.size() != 0) begin
      errors++; $display("FAIL ignore_junk writes %0d pushes %0d exp single 744", act_wr.size(), act_fifo.size());
    end
  endtask

  task automatic test_reset_alu();
    clear_logs();
    alu_delay = 1000;
    send_byte(8'hDD); send_byte(8'h01);
    tick(4);
    checks++;
    if ({ALU_EN, CLK_GATE_EN, ALU_FUN} !== 6'b11_0001) begin
      errors++; $display("FAIL alu_wait_entry got %b exp 110001", {ALU_EN, CLK_GATE_EN, ALU_FUN});
    end
    #2 RST = 1'b1;
    #1;
    checks++;
    if (all_outs() !== 29'h0) begin
      errors++; $display("FAIL async_reset got %h exp 0", all_outs());
    end
    tick(1);
    RST = 1'b0;
    alu_delay = 3;
    clear_logs();
    send_byte(8'hAA); send_byte(8'h03); send_byte(8'h20);
    ref_mem[3] = 8'h20;
    tick(4);
    checks++;
    if (act_wr.size() != 1 || act_wr[0] !== wr_t'({4'h3, 8'h20}) || act_fifo.size() != 0) begin
      errors++; $display("FAIL post_reset_write writes %0d pushes %0d exp single 320", act_wr.size(), act_fifo.size());
    end
  endtask

  task automatic test_random();
    logic [7:0]  x, y;
    logic [3:0]  f;
    logic [15:0] v;
    int          kind;
    clear_logs();
    exp_wr.delete(); exp_fifo.delete(); exp_rd.delete(); exp_fun.delete();
    excl_err  = 0;
    gate_err  = 0;
    rand_full = 1;
    for (int n = 0; n < 40; n++) begin
      kind      = int'($urandom_range(0, 4));
      alu_delay = int'($urandom_range(0, 6));
      x = 8'($urandom); y = 8'($urandom); f = 4'($urandom); v = 16'($urandom);
      alu_value = v;
      case (kind)
        0: begin
          send_byte(8'hAA); send_byte(x); send_byte(y);
          exp_wr.push_back(wr_t'({x[3:0], y})); ref_mem[x[3:0]] = y;
          tick(3);
        end
        1: begin
          send_byte(8'hBB); send_byte(x);
          exp_rd.push_back(x[3:0]); exp_fifo.push_back(ref_mem[x[3:0]]);
          wait_fifo(exp_fifo.size());
        end
        2, 3: begin
          if (kind == 2) begin
            send_byte(8'hCC); send_byte(x); send_byte(y);
            exp_wr.push_back(wr_t'({4'h0, x})); exp_wr.push_back(wr_t'({4'h1, y}));
            ref_mem[0] = x; ref_mem[1] = y;
          end else begin
            send_byte(8'hDD);
          end
          send_byte({4'($urandom), f});
          exp_fun.push_back(f);
          exp_fifo.push_back(v[7:0]); exp_fifo.push_back(v[15:8]);
          wait_fifo(exp_fifo.size());
        end
        default: begin
          if (x inside {8'hAA, 8'hBB, 8'hCC, 8'hDD}) x = 8'h55;
          send_byte(x);
        end
      endcase
    end
    rand_full = 0;
    FIFO_FULL = 1'b0;
    tick(5);
    checks++;
    if (act_wr.size() != exp_wr.size()) begin
      errors++; $display("FAIL rand_write_count got %0d exp %0d", act_wr.size(), exp_wr.size());
    end else begin
      foreach (exp_wr[i]) begin
        checks++;
        if (act_wr[i] !== exp_wr[i]) begin
          errors++; $display("FAIL rand_write[%0d] got %h exp %h", i, act_wr[i], exp_wr[i]);
        end
      end
    end
    checks++;
    if (act_fifo.size() != exp_fifo.size()) begin
      errors++; $display("FAIL rand_push_count got %0d exp %0d", act_fifo.size(), exp_fifo.size());
    end else begin
      foreach (exp_fifo[i]) begin
        checks++;
        if (act_fifo[i] !== exp_fifo[i]) begin
          errors++; $display("FAIL rand_push[%0d] got %h exp %h", i, act_fifo[i], exp_fifo[i]);
        end
      end
    end
    checks++;
    if (act_rd != exp_rd || act_fun != exp_fun) begin
      errors++; $display("FAIL rand_rd_fun reads %0d/%0d funs %0d/%0d", act_rd.size(), exp_rd.size(), act_fun.size(), exp_fun.size());
    end
    checks++;
    if (excl_err != 0 || gate_err != 0) begin
      errors++; $display("FAIL strobe_rules got excl %0d gate %0d exp 0 0", excl_err, gate_err);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    for (int i = 0; i < 16; i++) begin rf_mem[i] = 8'h00; ref_mem[i] = 8'h00; end
    RST = 1'b1; RX_P_DATA = '0; RX_D_VLD = 1'b0; FIFO_FULL = 1'b0;
    RF_RD_DATA = '0; RF_RD_VLD = 1'b0; ALU_OUT = '0; ALU_OUT_VLD = 1'b0;
    rand_full = 0; alu_delay = 3; alu_value = '0;
    test_reset();
    test_write();
    test_read();
    test_alu_op();
    test_back_to_back();
    test_backpressure();
    test_ignore();
    test_reset_alu();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
